// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decode-to-execute register feeding a combinational ALU.
// Resolves EX/WB operand forwarding, immediate/shamt selection, the load-use
// interlock, flush and valid/ready backpressure; out_* are registered and
// drive the ALU directly.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 squash held instruction and current input
//   in_valid/in_ready     decode handshake (in_ready independent of in_valid)
//   in_opcode..in_dest    decoded instruction fields and register-file reads
//   ex_fwd_*, wb_fwd_*    forwarding sources, EX has priority over WB
//   load_pend, load_addr  pending load in EX whose data is not yet available
//   out_valid/out_ready   execute handshake
//   out_opcode/a/b/dest   registered ALU inputs and destination
module alu_operand_stage #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_opcode,
    input  logic [ADDR_SIZE-1:0] in_rs_addr,
    input  logic [ADDR_SIZE-1:0] in_rt_addr,
    input  logic [WORD_SIZE-1:0] in_rs_data,
    input  logic [WORD_SIZE-1:0] in_rt_data,
    input  logic [15:0]          in_imm,
    input  logic [4:0]           in_shamt,
    input  logic                 in_use_imm,
    input  logic                 in_sign_ext,
    input  logic                 in_use_shamt,
    input  logic [ADDR_SIZE-1:0] in_dest,
    input  logic                 ex_fwd_en,
    input  logic [ADDR_SIZE-1:0] ex_fwd_addr,
    input  logic [WORD_SIZE-1:0] ex_fwd_data,
    input  logic                 wb_fwd_en,
    input  logic [ADDR_SIZE-1:0] wb_fwd_addr,
    input  logic [WORD_SIZE-1:0] wb_fwd_data,
    input  logic                 load_pend,
    input  logic [ADDR_SIZE-1:0] load_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_opcode,
    output logic [WORD_SIZE-1:0] out_a,
    output logic [WORD_SIZE-1:0] out_b,
    output logic [ADDR_SIZE-1:0] out_dest
);
    logic                 hazard;
    logic                 accept;
    logic [WORD_SIZE-1:0] fwd_rs;
    logic [WORD_SIZE-1:0] fwd_rt;
    logic [WORD_SIZE-1:0] sel_a;
    logic [WORD_SIZE-1:0] sel_b;

    // A pending load only stalls operands that are actually read from the register file.
    assign hazard = load_pend && (load_addr != '0) &&
                    ((!in_use_shamt && in_rs_addr == load_addr) ||
                     (!in_use_imm && in_rt_addr == load_addr));
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Register 0 is hardwired to zero and must never pick up forwarded data.
    assign fwd_rs = (in_rs_addr == '0) ? '0 :
                    (ex_fwd_en && ex_fwd_addr == in_rs_addr) ? ex_fwd_data :
                    (wb_fwd_en && wb_fwd_addr == in_rs_addr) ? wb_fwd_data : in_rs_data;
    assign fwd_rt = (in_rt_addr == '0) ? '0 :
                    (ex_fwd_en && ex_fwd_addr == in_rt_addr) ? ex_fwd_data :
                    (wb_fwd_en && wb_fwd_addr == in_rt_addr) ? wb_fwd_data : in_rt_data;

    assign sel_a = in_use_shamt ? {{(WORD_SIZE-5){1'b0}}, in_shamt} : fwd_rs;
    assign sel_b = in_use_imm ? {{(WORD_SIZE-16){in_sign_ext & in_imm[15]}}, in_imm} : fwd_rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_a      <= '0;
            out_b      <= '0;
            out_dest   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_opcode <= in_opcode;
            out_a      <= sel_a;
            out_b      <= sel_b;
            out_dest   <= in_dest;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed and randomized checks of alu_operand_stage against a scoreboard model.
module tb_alu_operand_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [4:0]  in_rs_addr, in_rt_addr, in_dest;
    logic [31:0] in_rs_data, in_rt_data;
    logic [15:0] in_imm;
    logic [4:0]  in_shamt;
    logic        in_use_imm, in_sign_ext, in_use_shamt;
    logic        ex_fwd_en, wb_fwd_en, load_pend;
    logic [4:0]  ex_fwd_addr, wb_fwd_addr, load_addr;
    logic [31:0] ex_fwd_data, wb_fwd_data;
    logic        out_valid, out_ready;
    logic [3:0]  out_opcode;
    logic [31:0] out_a, out_b;
    logic [4:0]  out_dest;

    int compared = 0;
    int mismatched = 0;

    logic        exp_valid;
    logic [3:0]  exp_op;
    logic [31:0] exp_a, exp_b;
    logic [4:0]  exp_dest;

    localparam logic [3:0] ADD = 4'h1;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm), .in_shamt(in_shamt),
        .in_use_imm(in_use_imm), .in_sign_ext(in_sign_ext), .in_use_shamt(in_use_shamt),
        .in_dest(in_dest), .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
        .load_pend(load_pend), .load_addr(load_addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_a(out_a), .out_b(out_b), .out_dest(out_dest)
    );

    function automatic logic [31:0] m_src(input logic [4:0] x, input logic [31:0] rf);
        if (x == 0) return 32'd0;
        if (ex_fwd_en && ex_fwd_addr == x) return ex_fwd_data;
        if (wb_fwd_en && wb_fwd_addr == x) return wb_fwd_data;
        return rf;
    endfunction

    function automatic logic [31:0] m_a();
        return in_use_shamt ? 32'(in_shamt) : m_src(in_rs_addr, in_rs_data);
    endfunction

    function automatic logic [31:0] m_b();
        if (!in_use_imm) return m_src(in_rt_addr, in_rt_data);
        return in_sign_ext ? 32'(signed'(in_imm)) : 32'(in_imm);
    endfunction

    function automatic logic m_ready();
        logic stall;
        stall = load_pend && load_addr != 0 &&
                ((!in_use_shamt && in_rs_addr == load_addr) || (!in_use_imm && in_rt_addr == load_addr));
        return !flush && !stall && (!exp_valid || out_ready);
    endfunction

    // Advance one clock and move the scoreboard the way the stage should.
    task automatic tick();
        logic        acc, nv;
        logic [3:0]  nop;
        logic [31:0] na, nb;
        logic [4:0]  nd;
        acc = in_valid && m_ready();
        nv = exp_valid; nop = exp_op; na = exp_a; nb = exp_b; nd = exp_dest;
        if (flush) nv = 1'b0;
        else if (acc) begin
            nv = 1'b1; nop = in_opcode; na = m_a(); nb = m_b(); nd = in_dest;
        end else if (exp_valid && out_ready) nv = 1'b0;
        @(posedge clk);
        exp_valid = nv; exp_op = nop; exp_a = na; exp_b = nb; exp_dest = nd;
        #1;
    endtask

    task automatic set_idle();
        flush = 0; in_valid = 0; in_opcode = 0; in_rs_addr = 0; in_rt_addr = 0;
        in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_shamt = 0; in_use_imm = 0;
        in_sign_ext = 0; in_use_shamt = 0; in_dest = 0; ex_fwd_en = 0; ex_fwd_addr = 0;
        ex_fwd_data = 0; wb_fwd_en = 0; wb_fwd_addr = 0; wb_fwd_data = 0;
        load_pend = 0; load_addr = 0; out_ready = 1;
    endtask

    task automatic set_add();
        set_idle();
        in_valid = 1; in_opcode = ADD; in_rs_addr = 3; in_rt_addr = 4;
        in_rs_data = 32'h10; in_rt_data = 32'h20; in_dest = 7;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 0;
        exp_valid = 0; exp_op = 0; exp_a = 0; exp_b = 0; exp_dest = 0;
        #1;
        compared++;
        if ({out_valid, out_opcode, out_a, out_b, out_dest} !== '0) begin
            mismatched++;
            $display("FAIL reset: got v=%b op=%h a=%h b=%h d=%h, need all zero", out_valid, out_opcode, out_a, out_b, out_dest);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk); #1;
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: out_valid got %b need 0", out_valid);
        end
    endtask

    task automatic test_basic();
        set_add();
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_ready: got %b need 1", in_ready);
        end
        tick();
        compared++;
        if (out_valid !== 1'b1 || out_opcode !== ADD || out_a !== 32'h10 || out_b !== 32'h20 || out_dest !== 5'd7) begin
            mismatched++;
            $display("FAIL basic: got v=%b op=%h a=%h b=%h d=%h need 1 %h 10 20 7", out_valid, out_opcode, out_a, out_b, out_dest, ADD);
        end
    endtask

    task automatic test_forward();
        set_add();
        ex_fwd_en = 1; ex_fwd_addr = 3; ex_fwd_data = 32'hAAAA;
        wb_fwd_en = 1; wb_fwd_addr = 3; wb_fwd_data = 32'hBBBB;
        tick();
        compared++;
        if (out_a !== 32'hAAAA || out_b !== 32'h20) begin
            mismatched++;
            $display("FAIL fwd_ex_priority: got a=%h b=%h need a=0000aaaa b=00000020", out_a, out_b);
        end
        ex_fwd_en = 0;
        tick();
        compared++;
        if (out_a !== 32'hBBBB) begin
            mismatched++;
            $display("FAIL fwd_wb: got a=%h need 0000bbbb", out_a);
        end
        ex_fwd_en = 1; in_rs_addr = 0; in_rs_data = 32'h1234;
        ex_fwd_addr = 0; wb_fwd_addr = 0;
        tick();
        compared++;
        if (out_a !== 32'h0) begin
            mismatched++;
            $display("FAIL fwd_r0: got a=%h need 0", out_a);
        end
    endtask

    task automatic test_imm_shamt();
        set_add();
        in_use_imm = 1; in_imm = 16'h8000; in_sign_ext = 1;
        tick();
        compared++;
        if (out_b !== 32'hFFFF8000) begin
            mismatched++;
            $display("FAIL imm_sext: got b=%h need ffff8000", out_b);
        end
        in_sign_ext = 0;
        tick();
        compared++;
        if (out_b !== 32'h00008000) begin
            mismatched++;
            $display("FAIL imm_zext: got b=%h need 00008000", out_b);
        end
        in_use_imm = 0; in_use_shamt = 1; in_shamt = 7;
        tick();
        compared++;
        if (out_a !== 32'd7 || out_b !== 32'h20) begin
            mismatched++;
            $display("FAIL shamt: got a=%h b=%h need 7 20", out_a, out_b);
        end
    endtask

    task automatic test_load_use();
        set_add();
        in_rt_addr = 5; in_rt_data = 32'h55; load_pend = 1; load_addr = 5;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL load_stall_ready: got %b need 0", in_ready);
        end
        tick();
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL load_bubble: out_valid got %b need 0", out_valid);
        end
        load_pend = 0;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL load_resume_ready: got %b need 1", in_ready);
        end
        tick();
        compared++;
        if (out_valid !== 1'b1 || out_b !== 32'h55) begin
            mismatched++;
            $display("FAIL load_resume: got v=%b b=%h need 1 00000055", out_valid, out_b);
        end
        load_pend = 1; in_use_imm = 1; in_imm = 16'h0042;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL load_imm_nostall: in_ready got %b need 1", in_ready);
        end
        tick();
        compared++;
        if (out_valid !== 1'b1 || out_b !== 32'h42) begin
            mismatched++;
            $display("FAIL load_imm: got v=%b b=%h need 1 00000042", out_valid, out_b);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ha, hb;
        set_add();
        tick();
        ha = out_a; hb = out_b;
        out_ready = 0; in_rs_data = 32'h99; in_rt_data = 32'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_a !== ha || out_b !== hb) begin
                mismatched++;
                $display("FAIL backpressure[%0d]: got rdy=%b v=%b a=%h b=%h need 0 1 %h %h", i, in_ready, out_valid, out_a, out_b, ha, hb);
            end
            tick();
        end
        out_ready = 1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_ready: got %b need 1", in_ready);
        end
        tick();
        compared++;
        if (out_valid !== 1'b1 || out_a !== 32'h99 || out_b !== 32'h77) begin
            mismatched++;
            $display("FAIL b2b: got v=%b a=%h b=%h need 1 99 77", out_valid, out_a, out_b);
        end
    endtask

    task automatic test_flush();
        set_add();
        tick();
        flush = 1;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_ready: got %b need 0", in_ready);
        end
        tick();
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL flush: out_valid got %b need 0", out_valid);
        end
        flush = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            flush = ($urandom_range(0, 15) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            in_opcode = 4'($urandom);
            in_rs_addr = 5'($urandom_range(0, 5));
            in_rt_addr = 5'($urandom_range(0, 5));
            in_rs_data = $urandom; in_rt_data = $urandom;
            in_imm = 16'($urandom); in_shamt = 5'($urandom);
            in_use_imm = $urandom_range(0, 2) == 0;
            in_sign_ext = 1'($urandom);
            in_use_shamt = $urandom_range(0, 3) == 0;
            in_dest = 5'($urandom);
            ex_fwd_en = 1'($urandom); ex_fwd_addr = 5'($urandom_range(0, 5)); ex_fwd_data = $urandom;
            wb_fwd_en = 1'($urandom); wb_fwd_addr = 5'($urandom_range(0, 5)); wb_fwd_data = $urandom;
            load_pend = $urandom_range(0, 2) == 0; load_addr = 5'($urandom_range(0, 5));
            out_ready = $urandom_range(0, 3) != 0;
            #1;
            compared++;
            if (in_ready !== m_ready()) begin
                mismatched++;
                $display("FAIL rand_ready[%0d]: got %b need %b", n, in_ready, m_ready());
            end
            tick();
            compared++;
            if (out_valid !== exp_valid || out_opcode !== exp_op || out_a !== exp_a || out_b !== exp_b || out_dest !== exp_dest) begin
                mismatched++;
                $display("FAIL rand_out[%0d]: got v=%b op=%h a=%h b=%h d=%h need %b %h %h %h %h", n,
                         out_valid, out_opcode, out_a, out_b, out_dest, exp_valid, exp_op, exp_a, exp_b, exp_dest);
            end
        end
    endtask

    task automatic test_async_reset();
        set_add();
        tick();
        #2 rst_n = 0;
        #1;
        compared++;
        if ({out_valid, out_opcode, out_a, out_b, out_dest} !== '0) begin
            mismatched++;
            $display("FAIL async_reset: got v=%b op=%h a=%h b=%h d=%h need all zero", out_valid, out_opcode, out_a, out_b, out_dest);
        end
        exp_valid = 0; exp_op = 0; exp_a = 0; exp_b = 0; exp_dest = 0;
        @(negedge clk) rst_n = 1;
        set_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_imm_shamt();
        test_load_use();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Decode-to-execute pipeline register that feeds the ALU: captures the decoded ALU opcode and register fields, resolves operand forwarding, and presents registered opcode/a/b to the ALU.
- Handles the load-use interlock, pipeline flush and valid/ready backpressure.
- The ALU is purely combinational, so out_opcode/out_a/out_b drive it directly and the result is available in the same cycle as the outputs.

Parameters:
- WORD_SIZE, 32, datapath width of operands.
- ADDR_SIZE, 5, register-file address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of the held instruction and the current input.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_opcode  in  4  ALU opcode, same encoding the ALU decodes.
- in_rs_addr  in  ADDR_SIZE  source register s.
- in_rt_addr  in  ADDR_SIZE  source register t.
- in_rs_data  in  WORD_SIZE  register-file read of rs.
- in_rt_data  in  WORD_SIZE  register-file read of rt.
- in_imm  in  16  instruction immediate.
- in_shamt  in  5  constant shift amount.
- in_use_imm  in  1  b = extended immediate instead of rt.
- in_sign_ext  in  1  sign-extend (1) or zero-extend (0) in_imm.
- in_use_shamt  in  1  a = zero-extended in_shamt instead of rs.
- in_dest  in  ADDR_SIZE  destination register; passed through.
- ex_fwd_en  in  1  EX/MEM result is valid for forwarding.
- ex_fwd_addr  in  ADDR_SIZE  EX/MEM destination.
- ex_fwd_data  in  WORD_SIZE  EX/MEM result.
- wb_fwd_en  in  1  MEM/WB result is valid for forwarding.
- wb_fwd_addr  in  ADDR_SIZE  MEM/WB destination.
- wb_fwd_data  in  WORD_SIZE  MEM/WB result.
- load_pend  in  1  a load whose data is not yet available is in EX.
- load_addr  in  ADDR_SIZE  destination of that load.
- out_valid  out  1  registered instruction valid.
- out_ready  in  1  execute consumes this cycle.
- out_opcode  out  4  to ALU opcode.
- out_a  out  WORD_SIZE  to ALU a.
- out_b  out  WORD_SIZE  to ALU b.
- out_dest  out  ADDR_SIZE  destination register.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_opcode=0, out_a=0, out_b=0, out_dest=0. Deassertion takes effect on the next rising edge.
- Operand usage:
  - uses_rs = !in_use_shamt.
  - uses_rt = !in_use_imm.
- hazard = load_pend && load_addr!=0 && ((uses_rs && in_rs_addr==load_addr) || (uses_rt && in_rt_addr==load_addr)).
- in_ready = !flush && !hazard && (!out_valid || out_ready). Purely combinational; in_ready does not depend on in_valid.
- accept = in_valid && in_ready.
- Forwarding, per source operand with address X:
  - Address 0 always yields 0, never forwarded.
  - Otherwise ex_fwd_data if ex_fwd_en && ex_fwd_addr==X (EX has priority).
  - Else wb_fwd_data if wb_fwd_en && wb_fwd_addr==X.
  - Else the register-file data.
- Operand selection:
  - a = in_use_shamt ? {zeros, in_shamt} : fwd(rs).
  - b = in_use_imm ? ext(in_imm) : fwd(rt).
  - ext(in_imm): sign-extend replicates bit 15 to WORD_SIZE; zero-extend pads with 0.
- Register update per clock, in priority order:
  1. flush: out_valid<=0. Data registers are don't-care and hold.
  2. accept: out_valid<=1, and all out_* load the selected values.
  3. out_valid && out_ready: out_valid<=0 (bubble; data hold).
  4. otherwise: hold everything.
- Load-use stall: while hazard is asserted, no accept occurs. The held instruction drains normally, so a bubble enters EX. Acceptance resumes in the first cycle hazard is low.
- Backpressure: if out_valid && !out_ready, out_* stay stable and in_ready=0.
- Simultaneous drain and accept (out_ready=1 while out_valid=1 and accept) gives back-to-back issue with no bubble; throughput is 1/cycle.
- Flush in the same cycle as in_valid: the input is dropped (in_ready=0) and out_valid=0 next cycle.
- Latency: input to out_* is exactly 1 cycle.

Test Plan:
- Reset, then in_valid=1, opcode=ADD, rs=3 (data 0x10), rt=4 (data 0x20), no forwarding -> next cycle out_valid=1, out_a=0x10, out_b=0x20, out_opcode=ADD.
- Same instruction with ex_fwd(addr 3, 0xAAAA) and wb_fwd(addr 3, 0xBBBB) both enabled -> out_a=0xAAAA. With rs=0 and both forwarding to addr 0 -> out_a=0.
- in_use_imm=1, in_imm=0x8000: sign_ext=1 -> out_b=0xFFFF8000; sign_ext=0 -> 0x00008000. Shift with in_use_shamt=1, shamt=7 -> out_a=7.
- load_pend=1, load_addr=5, rt=5, in_use_imm=0 -> in_ready=0 and out_valid drops after consumption. Drop load_pend -> accepted next cycle. Repeat with in_use_imm=1 -> no stall.
- out_ready=0 for 3 cycles while out_valid=1 -> out_* constant and in_ready=0. Then out_ready=1 with in_valid=1 -> new instruction loaded with no bubble.
- flush=1 with out_valid=1 and in_valid=1 -> in_ready=0, out_valid=0 next cycle. Assert rst_n=0 mid-stream -> outputs 0 immediately, without waiting for a clock.
